i2c_reg_sequencer: RTL and testbench
====================================

Name: i2c_reg_sequencer

Overview:
Transaction-level controller that sits between a register-access client and the byte-level I2C master. It turns one request (device, register, read/write, 1-4 bytes) into the full command sequence: START / WR / RESTART / RD / STOP. It handles the master's ready/done_tick handshake, checks the slave acknowledge bits, and returns one response per request, with an error code and read data.

Parameters:
MAX_LEN, 4, maximum burst length in bytes (data bus width = 8*MAX_LEN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request strobe; sampled only when req_ready=1
req_ready  out  1  sequencer idle and able to accept a request
req_rw  in  1  0=write, 1=read
req_dev  in  7  7-bit slave address
req_reg  in  8  register/sub-address byte
req_len  in  3  byte count, valid range 1..MAX_LEN
req_wdata  in  32  write bytes; byte k = [8k+7:8k], byte 0 sent first
rsp_valid  out  1  single-cycle response pulse
rsp_err  out  2  00 ok, 01 address NACK, 10 register/data NACK, 11 bad length or timeout
rsp_rdata  out  32  read bytes; byte k = [8k+7:8k], unused bytes zero
i2c_cmd  out  3  command to master (START 000, WR 001, RD 010, STOP 011, RESTART 100)
i2c_din  out  8  byte to master
i2c_wr  out  1  single-cycle command strobe to master
i2c_ready  in  1  master ready
i2c_done_tick  in  1  master byte-complete pulse
i2c_ack  in  1  acknowledge bit from last byte (0=ACK, 1=NACK)
i2c_dout  in  8  byte received from master

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_err=00, rsp_rdata=0, i2c_wr=0, i2c_cmd=000, i2c_din=00. Reset mid-transaction abandons the sequence; no STOP is sent.
- Request acceptance: a request is captured when req_valid && req_ready. All request fields are registered. req_ready is low from the next cycle until the cycle after rsp_valid.
- req_len=0 or req_len>MAX_LEN: no bus activity. rsp_valid is asserted 1 cycle after acceptance with rsp_err=11.
- Step list, driven by a step counter:
  - write: START; WR {dev,0}; WR reg; WR data[0..len-1]; STOP
  - read: START; WR {dev,0}; WR reg; RESTART; WR {dev,1}; RD x len; STOP
- RD din: 8'h01 (NACK) on the last byte, 8'h00 otherwise.
- FSM states:
  - IDLE: accept a request and move to ISSUE.
  - ISSUE: wait for i2c_ready=1, then pulse i2c_wr with the cmd/din for the current step, and go to GAP.
  - GAP: one cycle that ignores i2c_ready while the master's ready falls.
    - WR/RD steps go to WAIT_DONE.
    - START/RESTART/STOP go to WAIT_RDY.
  - WAIT_DONE: on i2c_done_tick, capture i2c_ack and, for RD, i2c_dout into the byte slot.
    - WR with i2c_ack=1 (NACK): record err (01 on the address bytes, including the repeated-start address; 10 otherwise), jump the step pointer to STOP, go to ISSUE.
    - Otherwise advance the step and go to ISSUE.
  - WAIT_RDY: after START/RESTART, advance the step and go to ISSUE. After STOP, wait for i2c_ready=1, then go to RESP.
  - RESP: pulse rsp_valid with rsp_err and rsp_rdata, then go to IDLE.
- Command issue rule: i2c_wr is never asserted while i2c_ready=0, and never twice for the same step.
- rsp_rdata and rsp_err hold their values until the next rsp_valid.
- i2c_ack is ignored on RD steps.

Optional Feature:
Macro I2C_SEQ_TIMEOUT_EN.
- Defined: a 24-bit watchdog counter is cleared on every i2c_wr and increments in GAP/WAIT_DONE/WAIT_RDY. When it reaches 2^24-1, the sequencer forces rsp_err=11, skips the STOP, and goes to RESP.
- Not defined: no counter, and the sequencer waits indefinitely.

Decomposition:
- Package i2c_pkg holds:
  - the command constants (START_CMD, WR_CMD, RD_CMD, STOP_CMD, RESTART_CMD)
  - the sequencer state enum
  - the rsp_err code constants
  - the step-to-{cmd,din} decode function, shared with the bench model
- Single module, no sub-module. The watchdog is inline under the macro.

Test Plan:
- Write, dev=7'h50, reg=8'h10, len=2, wdata=32'h0000BEEF, slave ACKs all -> master sees START, WR A0, WR 10, WR EF, WR BE, STOP; rsp_err=00.
- Read, dev=7'h50, reg=8'h20, len=3, slave returns 11,22,33 -> sequence START, WR A0, WR 20, RESTART, WR A1, RD(00), RD(00), RD(01), STOP; rsp_rdata=32'h00332211, rsp_err=00.
- Address NACK on WR A0 -> next command is STOP, no WR reg issued; rsp_err=01.
- Data NACK on the second write byte of len=4 -> STOP issued after that byte; rsp_err=10; remaining bytes not sent.
- req_len=0, then req_len=5 -> no i2c_wr activity; rsp_valid after 1 cycle with rsp_err=11 for each.
- Assert reset while in WAIT_DONE -> next cycle req_ready=1, i2c_wr=0, rsp_valid=0; a following write completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C register sequencer.
//   - byte-level master command codes (START/WR/RD/STOP/RESTART)
//   - sequencer state encoding and response error codes
//   - step decode helpers that map a step index of a request onto the
//     {cmd, din} pair handed to the byte-level master
package i2c_pkg;

  localparam int STEP_W = 4;

  localparam logic [2:0] START_CMD   = 3'b000;
  localparam logic [2:0] WR_CMD      = 3'b001;
  localparam logic [2:0] RD_CMD      = 3'b010;
  localparam logic [2:0] STOP_CMD    = 3'b011;
  localparam logic [2:0] RESTART_CMD = 3'b100;

  typedef logic [2:0] seq_state_t;
  localparam seq_state_t ST_IDLE      = 3'd0;
  localparam seq_state_t ST_ISSUE     = 3'd1;
  localparam seq_state_t ST_GAP       = 3'd2;
  localparam seq_state_t ST_WAIT_DONE = 3'd3;
  localparam seq_state_t ST_WAIT_RDY  = 3'd4;
  localparam seq_state_t ST_RESP      = 3'd5;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_ADDR_NACK = 2'b01;
  localparam logic [1:0] ERR_DATA_NACK = 2'b10;
  localparam logic [1:0] ERR_BAD       = 2'b11;

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] din;
  } i2c_op_t;

  // Write: START, WR {dev,0}, WR reg, WR data x len, STOP
  // Read : START, WR {dev,0}, WR reg, RESTART, WR {dev,1}, RD x len, STOP
  // wbyte is the write byte already selected for this step by the caller.
  function automatic i2c_op_t step_decode(input logic [STEP_W-1:0] step,
                                          input logic              rw,
                                          input logic [6:0]        dev,
                                          input logic [7:0]        regAddr,
                                          input logic [2:0]        len,
                                          input logic [7:0]        wbyte);
    logic [STEP_W-1:0] lenExt;
    i2c_op_t op;
    lenExt = {1'b0, len};
    op.cmd = STOP_CMD;
    op.din = 8'h00;
    if (step == 4'd0) begin
      op.cmd = START_CMD;
    end else if (step == 4'd1) begin
      op.cmd = WR_CMD;
      op.din = {dev, 1'b0};
    end else if (step == 4'd2) begin
      op.cmd = WR_CMD;
      op.din = regAddr;
    end else if (!rw) begin
      if (step < lenExt + 4'd3) begin
        op.cmd = WR_CMD;
        op.din = wbyte;
      end
    end else if (step == 4'd3) begin
      op.cmd = RESTART_CMD;
    end else if (step == 4'd4) begin
      op.cmd = WR_CMD;
      op.din = {dev, 1'b1};
    end else if (step < lenExt + 4'd5) begin
      op.cmd = RD_CMD;
      op.din = (step == lenExt + 4'd4) ? 8'h01 : 8'h00;
    end
    return op;
  endfunction

  function automatic logic [STEP_W-1:0] stop_step(input logic rw, input logic [2:0] len);
    return {1'b0, len} + (rw ? 4'd5 : 4'd3);
  endfunction

  // Address bytes are the first WR and, on reads, the repeated-start WR.
  function automatic logic is_addr_step(input logic rw, input logic [STEP_W-1:0] step);
    return (step == 4'd1) || (rw && (step == 4'd4));
  endfunction

endpackage

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns one register-access request (device, register,
// read/write, 1..MAX_LEN bytes) into the START/WR/RESTART/RD/STOP command
// sequence of a byte-level I2C master and returns one response per request.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_rw/dev/reg/len/wdata   request fields (byte 0 of wdata sent first)
//   rsp_valid/rsp_err/rsp_rdata single-cycle response with held err/data
//   i2c_cmd/i2c_din/i2c_wr     command to the byte-level master
//   i2c_ready/done_tick/ack/dout status and data from the master
//
// Build option: define I2C_SEQ_TIMEOUT_EN to add a 24-bit watchdog that
// aborts a stuck transaction with rsp_err=11 (no STOP is sent).
module i2c_reg_sequencer
  import i2c_pkg::*;
#(
  parameter int MAX_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rw,
  input  logic [6:0]           req_dev,
  input  logic [7:0]           req_reg,
  input  logic [2:0]           req_len,
  input  logic [8*MAX_LEN-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_err,
  output logic [8*MAX_LEN-1:0] rsp_rdata,
  output logic [2:0]           i2c_cmd,
  output logic [7:0]           i2c_din,
  output logic                 i2c_wr,
  input  logic                 i2c_ready,
  input  logic                 i2c_done_tick,
  input  logic                 i2c_ack,
  input  logic [7:0]           i2c_dout
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  seq_state_t           state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [1:0]           err_q, err_d;
  logic [8*MAX_LEN-1:0] rdata_q, rdata_d;
  logic [1:0]           rspErr_q, rspErr_d;
  logic [8*MAX_LEN-1:0] rspRdata_q, rspRdata_d;
  logic [2:0]           cmd_q, cmd_d;
  logic [7:0]           din_q, din_d;
  logic                 wr_q, wr_d;

  logic                 rw_q;
  logic [6:0]           dev_q;
  logic [7:0]           reg_q;
  logic [2:0]           len_q;
  logic [8*MAX_LEN-1:0] wdata_q;

  logic                 badLen;
  logic [IDX_W-1:0]     wIdx;
  logic [IDX_W-1:0]     rIdx;
  logic [7:0]           wByte;
  i2c_op_t              curOp;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam logic [23:0] WDOG_MAX = 24'hFFFFFF;
  logic [23:0] wdog_q, wdog_d;
  logic        wdogActive;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rspErr_q;
  assign rsp_rdata = rspRdata_q;
  assign i2c_cmd   = cmd_q;
  assign i2c_din   = din_q;
  assign i2c_wr    = wr_q;

  assign badLen = (req_len == 3'd0) || (int'(req_len) > MAX_LEN);

  // Data steps start at step 3 on writes and at step 5 on reads.
  assign wIdx  = IDX_W'(step_q - 4'd3);
  assign rIdx  = IDX_W'(step_q - 4'd5);
  assign wByte = wdata_q[8*wIdx +: 8];
  assign curOp = step_decode(step_q, rw_q, dev_q, reg_q, len_q, wByte);

  // Request fields are latched once, at acceptance, and stay stable for
  // the whole command sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
    end else if (req_ready && req_valid) begin
      rw_q    <= req_rw;
      dev_q   <= req_dev;
      reg_q   <= req_reg;
      len_q   <= req_len;
      wdata_q <= req_wdata;
    end
  end

  // Sequencer next-state logic. The response registers are loaded only on
  // the way into RESP so they hold between responses.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    rspErr_d   = rspErr_q;
    rspRdata_d = rspRdata_q;
    cmd_d      = cmd_q;
    din_d      = din_q;
    wr_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          step_d  = '0;
          err_d   = ERR_OK;
          rdata_d = '0;
          if (badLen) begin
            rspErr_d   = ERR_BAD;
            rspRdata_d = '0;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (i2c_ready) begin
          cmd_d   = curOp.cmd;
          din_d   = curOp.din;
          wr_d    = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ((cmd_q == WR_CMD) || (cmd_q == RD_CMD)) ? ST_WAIT_DONE : ST_WAIT_RDY;
      end
      ST_WAIT_DONE: begin
        if (i2c_done_tick) begin
          state_d = ST_ISSUE;
          step_d  = step_q + 4'd1;
          if (cmd_q == RD_CMD) begin
            rdata_d[8*rIdx +: 8] = i2c_dout;
          end else if (i2c_ack) begin
            err_d  = is_addr_step(rw_q, step_q) ? ERR_ADDR_NACK : ERR_DATA_NACK;
            step_d = stop_step(rw_q, len_q);
          end
        end
      end
      ST_WAIT_RDY: begin
        if (cmd_q != STOP_CMD) begin
          step_d  = step_q + 4'd1;
          state_d = ST_ISSUE;
        end else if (i2c_ready) begin
          rspErr_d   = err_q;
          rspRdata_d = rdata_q;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef I2C_SEQ_TIMEOUT_EN
    wdogActive = (state_q == ST_GAP) || (state_q == ST_WAIT_DONE) || (state_q == ST_WAIT_RDY);
    wdog_d     = wdog_q;
    if (wr_d) begin
      wdog_d = '0;
    end else if (wdogActive) begin
      wdog_d = wdog_q + 24'd1;
    end
    if (wdogActive && (wdog_q == WDOG_MAX)) begin
      rspErr_d   = ERR_BAD;
      rspRdata_d = rdata_d;
      state_d    = ST_RESP;
    end
`endif
  end

  // State and output registers; a reset abandons any sequence in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      err_q      <= ERR_OK;
      rdata_q    <= '0;
      rspErr_q   <= ERR_OK;
      rspRdata_q <= '0;
      cmd_q      <= START_CMD;
      din_q      <= 8'h00;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rspErr_q   <= rspErr_d;
      rspRdata_q <= rspRdata_d;
      cmd_q      <= cmd_d;
      din_q      <= din_d;
      wr_q       <= wr_d;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  // Watchdog restarts on every command strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: drives requests into i2c_reg_sequencer, plays the
// byte-level I2C master plus slave, and compares the observed command
// stream and responses against a transaction-level expectation.
module tb_i2c_reg_sequencer;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg;
  logic [2:0]  req_len;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [1:0]  rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  i2c_cmd;
  logic [7:0]  i2c_din;
  logic        i2c_wr;
  logic        i2c_ready;
  logic        i2c_done_tick;
  logic        i2c_ack;
  logic [7:0]  i2c_dout;

  int checks;
  int failures;
  int wrWhileBusy;
  int nackIdx;
  int slowMaster;

  logic [10:0] seenOps[$];
  logic [10:0] expOps[$];
  logic [7:0]  rdBytes[$];
  logic [7:0]  rdPlan[4];
  logic [1:0]  expErr;
  logic [31:0] expRdata;

  i2c_reg_sequencer #(.MAX_LEN(4)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw(req_rw),
    .req_dev(req_dev),
    .req_reg(req_reg),
    .req_len(req_len),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .i2c_cmd(i2c_cmd),
    .i2c_din(i2c_din),
    .i2c_wr(i2c_wr),
    .i2c_ready(i2c_ready),
    .i2c_done_tick(i2c_done_tick),
    .i2c_ack(i2c_ack),
    .i2c_dout(i2c_dout)
  );

  always #5 clk = ~clk;

  // Master/slave model: logs every strobed command, drops ready while busy,
  // then reports done (WR/RD) or just raises ready again.
  initial begin
    int   delay;
    int   pIdx;
    logic pending;
    logic [2:0] pcmd;
    i2c_ready = 1'b1;
    i2c_done_tick = 1'b0;
    i2c_ack = 1'b0;
    i2c_dout = 8'h00;
    pending = 1'b0;
    delay = 0;
    pIdx = 0;
    pcmd = 3'b000;
    forever begin
      @(negedge clk);
      i2c_done_tick = 1'b0;
      if (reset) begin
        pending = 1'b0;
        i2c_ready = 1'b1;
      end else if (i2c_wr) begin
        if (!i2c_ready || pending) wrWhileBusy++;
        pIdx = seenOps.size();
        seenOps.push_back({i2c_cmd, i2c_din});
        pcmd = i2c_cmd;
        pending = 1'b1;
        i2c_ready = 1'b0;
        delay = (slowMaster != 0) ? 12 : int'($urandom_range(1, 4));
      end else if (pending) begin
        delay--;
        if (delay == 0) begin
          pending = 1'b0;
          i2c_ready = 1'b1;
          if (pcmd == WR_CMD) begin
            i2c_done_tick = 1'b1;
            i2c_ack = (pIdx == nackIdx);
          end else if (pcmd == RD_CMD) begin
            i2c_done_tick = 1'b1;
            i2c_ack = ($urandom_range(0, 1) != 0);
            i2c_dout = (rdBytes.size() > 0) ? rdBytes.pop_front() : 8'h00;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Expected command list built from the request as a whole, cut short at
  // a NACKed write byte and always closed with STOP.
  task automatic buildExpected(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                               input int len, input logic [31:0] wd, input logic badLen);
    expOps.delete();
    expRdata = 32'h0;
    if (badLen) begin
      expErr = ERR_BAD;
      return;
    end
    expOps.push_back({START_CMD, 8'h00});
    expOps.push_back({WR_CMD, dev, 1'b0});
    expOps.push_back({WR_CMD, rg});
    if (rw) begin
      expOps.push_back({RESTART_CMD, 8'h00});
      expOps.push_back({WR_CMD, dev, 1'b1});
      for (int k = 0; k < len; k++) expOps.push_back({RD_CMD, (k == len - 1) ? 8'h01 : 8'h00});
    end else begin
      for (int k = 0; k < len; k++) expOps.push_back({WR_CMD, wd[8*k +: 8]});
    end
    expErr = ERR_OK;
    if (nackIdx >= 0) begin
      while (expOps.size() > nackIdx + 1) void'(expOps.pop_back());
      expErr = ((nackIdx == 1) || (rw && nackIdx == 4)) ? ERR_ADDR_NACK : ERR_DATA_NACK;
    end else if (rw) begin
      for (int k = 0; k < len; k++) expRdata[8*k +: 8] = rdPlan[k];
    end
    expOps.push_back({STOP_CMD, 8'h00});
  endtask

  task automatic applyStimulus(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                               input logic [2:0] len, input logic [31:0] wd, input int nIdx,
                               input string tag);
    logic gotReady;
    logic gotRsp;
    logic badLen;
    logic [1:0] obsErr;
    logic [31:0] obsRdata;
    int obsLat;
    int n;
    badLen = (len == 3'd0) || (len > 3'd4);
    nackIdx = nIdx;
    rdBytes.delete();
    for (int k = 0; k < 4; k++) rdBytes.push_back(rdPlan[k]);
    seenOps.delete();
    buildExpected(rw, dev, rg, int'(len), wd, badLen);
    gotReady = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin
        gotReady = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_req_ready"}, 32'(gotReady), 32'd1);
    req_rw = rw;
    req_dev = dev;
    req_reg = rg;
    req_len = len;
    req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput({tag, "_busy"}, 32'(req_ready), 32'd0);
    gotRsp = 1'b0;
    obsLat = 0;
    obsErr = 2'bxx;
    obsRdata = 'x;
    for (int i = 1; i <= 1000; i++) begin
      if (rsp_valid) begin
        gotRsp = 1'b1;
        obsLat = i;
        obsErr = rsp_err;
        obsRdata = rsp_rdata;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_rsp_seen"}, 32'(gotRsp), 32'd1);
    if (badLen) checkOutput({tag, "_latency"}, 32'(obsLat), 32'd1);
    checkOutput({tag, "_err"}, 32'(obsErr), 32'(expErr));
    checkOutput({tag, "_rdata"}, obsRdata, expRdata);
    @(negedge clk);
    checkOutput({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_err_hold"}, 32'(rsp_err), 32'(expErr));
    checkOutput({tag, "_rdata_hold"}, rsp_rdata, expRdata);
    checkOutput({tag, "_op_count"}, 32'(seenOps.size()), 32'(expOps.size()));
    n = (seenOps.size() < expOps.size()) ? seenOps.size() : expOps.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_op%0d", tag, i), 32'(seenOps[i]), 32'(expOps[i]));
    end
  endtask

  initial begin
    logic rw;
    logic [2:0] len;
    int nIdx;
    int found;
    checks = 0;
    failures = 0;
    wrWhileBusy = 0;
    nackIdx = -1;
    slowMaster = 0;
    for (int k = 0; k < 4; k++) rdPlan[k] = 8'h00;
    reset = 1'b1;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_dev = 7'h00;
    req_reg = 8'h00;
    req_len = 3'd0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_i2c_wr", 32'(i2c_wr), 32'd0);
    checkOutput("reset_i2c_cmd", 32'(i2c_cmd), 32'd0);
    checkOutput("reset_i2c_din", 32'(i2c_din), 32'd0);
    #2 reset = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BEEF, -1, "wr_len2");
    rdPlan[0] = 8'h11;
    rdPlan[1] = 8'h22;
    rdPlan[2] = 8'h33;
    applyStimulus(1'b1, 7'h50, 8'h20, 3'd3, 32'h0, -1, "rd_len3");
    applyStimulus(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BEEF, 1, "addr_nack");
    applyStimulus(1'b0, 7'h3C, 8'h44, 3'd4, 32'hDEADBEEF, 4, "data_nack");
    applyStimulus(1'b0, 7'h50, 8'h10, 3'd0, 32'h12345678, -1, "len0");
    applyStimulus(1'b1, 7'h50, 8'h10, 3'd5, 32'h12345678, -1, "len5");
    applyStimulus(1'b1, 7'h21, 8'h07, 3'd2, 32'h0, 4, "rd_raddr_nack");
    rdPlan[0] = 8'hA5;
    applyStimulus(1'b1, 7'h7F, 8'hFF, 3'd1, 32'h0, -1, "rd_len1");
    rdPlan[3] = 8'h44;
    applyStimulus(1'b1, 7'h01, 8'h00, 3'd4, 32'h0, -1, "rd_len4");

    slowMaster = 1;
    nackIdx = -1;
    seenOps.delete();
    req_rw = 1'b0;
    req_dev = 7'h50;
    req_reg = 8'h10;
    req_len = 3'd2;
    req_wdata = 32'h0000CAFE;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (seenOps.size() >= 2) begin
        found = 1;
        break;
      end
    end
    checkOutput("rst_reach_wait_done", 32'(found), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_mid_i2c_wr", 32'(i2c_wr), 32'd0);
    checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    slowMaster = 0;
    repeat (20) @(negedge clk);
    checkOutput("rst_no_stop", 32'(seenOps.size()), 32'd2);
    applyStimulus(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BEEF, -1, "after_reset");

    for (int t = 0; t < 24; t++) begin
      rw = ($urandom_range(0, 1) != 0);
      len = 3'($urandom_range(1, 4));
      for (int k = 0; k < 4; k++) rdPlan[k] = 8'($urandom());
      nIdx = -1;
      if ($urandom_range(0, 3) == 0) begin
        if (rw) begin
          case ($urandom_range(0, 2))
            0: nIdx = 1;
            1: nIdx = 2;
            default: nIdx = 4;
          endcase
        end else begin
          nIdx = int'($urandom_range(1, 2 + int'(len)));
        end
      end
      applyStimulus(rw, 7'($urandom()), 8'($urandom()), len, $urandom(), nIdx,
                    $sformatf("rand%0d", t));
    end

    checkOutput("wr_while_busy", 32'(wrWhileBusy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
